// File: rtl/mem_access_unit.sv
// Memory-stage access unit: lane alignment, byte strobes, load extension,
// and a registered bus request FSM that stalls the pipeline until data_ok.
module mem_access_unit #(
   parameter int XLEN = 64,
   parameter int AW   = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic              in_read,
   input  logic              in_write,
   input  logic [1:0]        in_size,
   input  logic              in_unsigned,
   input  logic [AW-1:0]     in_addr,
   input  logic [XLEN-1:0]   in_wdata,
   input  logic              flush,
   input  logic              advance,
   output logic              dreq_valid,
   output logic [AW-1:0]     dreq_addr,
   output logic [1:0]        dreq_size,
   output logic [XLEN/8-1:0] dreq_strobe,
   output logic [XLEN-1:0]   dreq_data,
   input  logic              dresp_data_ok,
   input  logic [XLEN-1:0]   dresp_data,
   output logic              out_valid,
   output logic [XLEN-1:0]   out_rdata,
   output logic              misalign,
   output logic              stall
);
   localparam int BYTES = XLEN / 8;
   localparam int OW    = $clog2(BYTES);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic             kill;
   logic [AW-1:0]    addr_q;
   logic [1:0]       size_q;
   logic [BYTES-1:0] strobe_q;
   logic [XLEN-1:0]  data_q;
   logic             uns_q;
   logic [OW-1:0]    off_q;
   logic [XLEN-1:0]  rdata_q;

   logic [OW-1:0]    off;
   logic             mem_op;
   logic             aligned;
   logic             go;
   logic             bad;
   logic [BYTES-1:0] lanes;
   logic [BYTES-1:0] strobe;
   logic [XLEN-1:0]  shifted;
   logic [XLEN-1:0]  wdata_al;

   assign off    = in_addr[OW-1:0];
   assign mem_op = in_valid & (in_read | in_write);
   assign go     = mem_op & aligned & ~flush;
   assign bad    = mem_op & ~aligned & ~flush;

   // Doubleword is treated as misaligned on a 32-bit datapath.
   always_comb begin
      aligned = 1'b0;
      unique case (in_size)
         2'd0: aligned = 1'b1;
         2'd1: aligned = ~in_addr[0];
         2'd2: aligned = (in_addr[1:0] == 2'b00);
         2'd3: aligned = (XLEN == 64) && (in_addr[2:0] == 3'b000);
      endcase
   end

   always_comb begin
      lanes = '0;
      for (int i = 0; i < BYTES; i++)
         lanes[i] = (i < (1 << in_size));
   end

   assign strobe  = in_write ? (lanes << off) : '0;
   assign shifted = in_wdata << {off, 3'b000};

   always_comb begin
      wdata_al = '0;
      for (int i = 0; i < BYTES; i++)
         wdata_al[8*i +: 8] = strobe[i] ? shifted[8*i +: 8] : 8'h00;
   end

   logic [XLEN-1:0]        sh;
   logic [XLEN-1:0]        tmp;
   logic [XLEN-1:0]        zx;
   logic signed [XLEN-1:0] sx;
   logic [XLEN-1:0]        ext;
   int                     shamt;

   // Left-justify the field, then shift back to sign- or zero-extend.
   always_comb begin
      sh    = dresp_data >> {off_q, 3'b000};
      shamt = 0;
      unique case (size_q)
         2'd0: shamt = XLEN - 8;
         2'd1: shamt = XLEN - 16;
         2'd2: shamt = XLEN - 32;
         2'd3: shamt = 0;
      endcase
      tmp = sh << shamt;
      zx  = tmp >> shamt;
      sx  = $signed(tmp) >>> shamt;
      ext = uns_q ? zx : sx;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         kill     <= 1'b0;
         addr_q   <= '0;
         size_q   <= '0;
         strobe_q <= '0;
         data_q   <= '0;
         uns_q    <= 1'b0;
         off_q    <= '0;
         rdata_q  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (go) begin
                  addr_q   <= in_addr;
                  size_q   <= in_size;
                  strobe_q <= strobe;
                  data_q   <= wdata_al;
                  uns_q    <= in_unsigned;
                  off_q    <= off;
                  state    <= REQ;
               end
            end
            REQ: begin
               if (dresp_data_ok) begin
                  kill <= 1'b0;
                  if (kill | flush) begin
                     state <= IDLE;
                  end else begin
                     rdata_q <= (|strobe_q) ? '0 : ext;
                     state   <= DONE;
                  end
               end else if (flush) begin
                  kill <= 1'b1;
               end
            end
            DONE: begin
               if (advance | flush)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign dreq_valid  = (state == REQ);
   assign dreq_addr   = addr_q;
   assign dreq_size   = size_q;
   assign dreq_strobe = strobe_q;
   assign dreq_data   = data_q;

   always_comb begin
      stall     = 1'b0;
      out_valid = 1'b0;
      misalign  = 1'b0;
      out_rdata = '0;
      unique case (state)
         IDLE: begin
            stall     = go;
            out_valid = bad;
            misalign  = bad;
         end
         REQ: stall = 1'b1;
         DONE: begin
            out_valid = ~flush;
            out_rdata = rdata_q;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: stores, loads, wait states,
// misalignment, flush during a request and reset during a request.
module tb_mem_access_unit;
   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_read;
   logic        in_write;
   logic [1:0]  in_size;
   logic        in_unsigned;
   logic [63:0] in_addr;
   logic [63:0] in_wdata;
   logic        flush;
   logic        advance;
   logic        dreq_valid;
   logic [63:0] dreq_addr;
   logic [1:0]  dreq_size;
   logic [7:0]  dreq_strobe;
   logic [63:0] dreq_data;
   logic        dresp_data_ok;
   logic [63:0] dresp_data;
   logic        out_valid;
   logic [63:0] out_rdata;
   logic        misalign;
   logic        stall;

   int errors = 0;
   int checks = 0;

   mem_access_unit #(.XLEN(64), .AW(64)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_read(in_read), .in_write(in_write),
      .in_size(in_size), .in_unsigned(in_unsigned),
      .in_addr(in_addr), .in_wdata(in_wdata),
      .flush(flush), .advance(advance),
      .dreq_valid(dreq_valid), .dreq_addr(dreq_addr),
      .dreq_size(dreq_size), .dreq_strobe(dreq_strobe),
      .dreq_data(dreq_data),
      .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
      .out_valid(out_valid), .out_rdata(out_rdata),
      .misalign(misalign), .stall(stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic op(input logic rd, input logic wr, input logic [1:0] sz,
                     input logic uns, input logic [63:0] a,
                     input logic [63:0] wd);
      in_valid = 1'b1; in_read = rd; in_write = wr; in_size = sz;
      in_unsigned = uns; in_addr = a; in_wdata = wd;
   endtask

   task automatic idle_in();
      in_valid = 1'b0; in_read = 1'b0; in_write = 1'b0;
   endtask

   task automatic chk_reset_outs(input string p);
      chk({p, "_dreq_valid"}, 64'(dreq_valid), 64'd0);
      chk({p, "_strobe"}, 64'(dreq_strobe), 64'd0);
      chk({p, "_addr"}, dreq_addr, 64'd0);
      chk({p, "_data"}, dreq_data, 64'd0);
      chk({p, "_out_valid"}, 64'(out_valid), 64'd0);
      chk({p, "_rdata"}, out_rdata, 64'd0);
      chk({p, "_misalign"}, 64'(misalign), 64'd0);
      chk({p, "_stall"}, 64'(stall), 64'd0);
   endtask

   // Single-cycle-response load: T0 present, T1 data_ok, T2 check DONE.
   task automatic load1(input string tag, input logic [1:0] sz,
                        input logic uns, input logic [63:0] a,
                        input logic [63:0] raw, input logic [63:0] exp);
      op(1'b1, 1'b0, sz, uns, a, 64'd0);
      #1 chk({tag, "_t0_stall"}, 64'(stall), 64'd1);
      tick(); idle_in();
      dresp_data_ok = 1'b1; dresp_data = raw;
      #1 chk({tag, "_t1_strobe"}, 64'(dreq_strobe), 64'd0);
      tick(); dresp_data_ok = 1'b0; dresp_data = 64'd0; advance = 1'b1;
      #1 chk({tag, "_out_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_rdata"}, out_rdata, exp);
      tick(); advance = 1'b0;
   endtask

   initial begin
      reset = 1'b1; idle_in(); in_size = 2'd0; in_unsigned = 1'b0;
      in_addr = 64'd0; in_wdata = 64'd0; flush = 1'b0; advance = 1'b0;
      dresp_data_ok = 1'b0; dresp_data = 64'd0;
      tick(); tick();
      reset = 1'b0;
      #1 chk_reset_outs("rst");

      // SB at 0x8000_0003
      tick();
      op(1'b0, 1'b1, 2'd0, 1'b0, 64'h8000_0003, 64'hAB);
      #1 chk("sb_t0_stall", 64'(stall), 64'd1);
      chk("sb_t0_dreq_valid", 64'(dreq_valid), 64'd0);
      tick(); idle_in(); dresp_data_ok = 1'b1;
      #1 chk("sb_t1_dreq_valid", 64'(dreq_valid), 64'd1);
      chk("sb_strobe", 64'(dreq_strobe), 64'h08);
      chk("sb_data", dreq_data, 64'h0000_0000_AB00_0000);
      chk("sb_size", 64'(dreq_size), 64'd0);
      chk("sb_addr", dreq_addr, 64'h8000_0003);
      chk("sb_t1_stall", 64'(stall), 64'd1);
      tick(); dresp_data_ok = 1'b0; advance = 1'b1;
      #1 chk("sb_t2_out_valid", 64'(out_valid), 64'd1);
      chk("sb_t2_stall", 64'(stall), 64'd0);
      chk("sb_t2_rdata", out_rdata, 64'd0);
      chk("sb_t2_dreq_valid", 64'(dreq_valid), 64'd0);
      tick(); advance = 1'b0;
      #1 chk("sb_t3_out_valid", 64'(out_valid), 64'd0);

      // SH at offset 2 with junk in the upper store-data bits
      op(1'b0, 1'b1, 2'd1, 1'b0, 64'h8000_0002, 64'hFFFF_FFFF_FFFF_1234);
      tick(); idle_in(); dresp_data_ok = 1'b1;
      #1 chk("sh_strobe", 64'(dreq_strobe), 64'h0C);
      chk("sh_data", dreq_data, 64'h0000_0000_1234_0000);
      tick(); dresp_data_ok = 1'b0; advance = 1'b1;
      tick(); advance = 1'b0;

      load1("lh", 2'd1, 1'b0, 64'h8000_0006,
            64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001);
      load1("lhu", 2'd1, 1'b1, 64'h8000_0006,
            64'h8001_0000_0000_0000, 64'h0000_0000_0000_8001);
      load1("lb", 2'd0, 1'b0, 64'h8000_0001,
            64'h0000_0000_0000_7F00, 64'h0000_0000_0000_007F);
      load1("lbn", 2'd0, 1'b0, 64'h8000_0007,
            64'hF000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFF0);
      load1("lw", 2'd2, 1'b0, 64'h8000_0000,
            64'h0000_0000_8000_0001, 64'hFFFF_FFFF_8000_0001);
      load1("ld", 2'd3, 1'b0, 64'h8000_0008,
            64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);

      // LWU with data_ok in the third REQ cycle
      op(1'b1, 1'b0, 2'd2, 1'b1, 64'h8000_0004, 64'd0);
      #1 chk("lwu_t0_stall", 64'(stall), 64'd1);
      tick(); idle_in();
      #1 chk("lwu_t1_stall", 64'(stall), 64'd1);
      chk("lwu_t1_addr", dreq_addr, 64'h8000_0004);
      chk("lwu_t1_size", 64'(dreq_size), 64'd2);
      tick();
      #1 chk("lwu_t2_stall", 64'(stall), 64'd1);
      chk("lwu_t2_dreq_valid", 64'(dreq_valid), 64'd1);
      chk("lwu_t2_addr", dreq_addr, 64'h8000_0004);
      tick(); dresp_data_ok = 1'b1; dresp_data = 64'hDEAD_BEEF_0000_0000;
      #1 chk("lwu_t3_stall", 64'(stall), 64'd1);
      chk("lwu_t3_size", 64'(dreq_size), 64'd2);
      chk("lwu_t3_out_valid", 64'(out_valid), 64'd0);
      tick(); dresp_data_ok = 1'b0; dresp_data = 64'd0;
      #1 chk("lwu_t4_out_valid", 64'(out_valid), 64'd1);
      chk("lwu_t4_stall", 64'(stall), 64'd0);
      chk("lwu_t4_rdata", out_rdata, 64'h0000_0000_DEAD_BEEF);
      // flush in DONE hides the result and returns to IDLE
      flush = 1'b1;
      #1 chk("done_flush_out_valid", 64'(out_valid), 64'd0);
      tick(); flush = 1'b0;
      #1 chk("done_flush_idle", 64'(out_valid), 64'd0);

      // Misaligned LW
      op(1'b1, 1'b0, 2'd2, 1'b0, 64'h8000_0002, 64'd0);
      #1 chk("mis_misalign", 64'(misalign), 64'd1);
      chk("mis_out_valid", 64'(out_valid), 64'd1);
      chk("mis_stall", 64'(stall), 64'd0);
      chk("mis_dreq_valid", 64'(dreq_valid), 64'd0);
      tick(); idle_in();
      #1 chk("mis_t1_dreq_valid", 64'(dreq_valid), 64'd0);
      chk("mis_t1_misalign", 64'(misalign), 64'd0);

      // Flush in IDLE: no request issued
      op(1'b1, 1'b0, 2'd3, 1'b0, 64'h8000_0010, 64'd0);
      flush = 1'b1;
      #1 chk("iflush_stall", 64'(stall), 64'd0);
      tick(); idle_in(); flush = 1'b0;
      #1 chk("iflush_dreq_valid", 64'(dreq_valid), 64'd0);

      // Flush in first REQ cycle, data_ok two cycles later
      op(1'b1, 1'b0, 2'd3, 1'b0, 64'h8000_0000, 64'd0);
      tick(); idle_in(); flush = 1'b1;
      #1 chk("rflush_t1_dreq_valid", 64'(dreq_valid), 64'd1);
      tick(); flush = 1'b0;
      #1 chk("rflush_t2_dreq_valid", 64'(dreq_valid), 64'd1);
      chk("rflush_t2_out_valid", 64'(out_valid), 64'd0);
      tick(); dresp_data_ok = 1'b1; dresp_data = 64'h1111_2222_3333_4444;
      #1 chk("rflush_t3_dreq_valid", 64'(dreq_valid), 64'd1);
      chk("rflush_t3_out_valid", 64'(out_valid), 64'd0);
      tick(); dresp_data_ok = 1'b0; dresp_data = 64'd0;
      #1 chk("rflush_t4_dreq_valid", 64'(dreq_valid), 64'd0);
      chk("rflush_t4_out_valid", 64'(out_valid), 64'd0);
      chk("rflush_t4_stall", 64'(stall), 64'd0);
      tick();
      #1 chk("rflush_t5_out_valid", 64'(out_valid), 64'd0);

      // Kill flag must not leak into the next access
      load1("post_kill", 2'd2, 1'b1, 64'h8000_0000,
            64'h0000_0000_1234_5678, 64'h0000_0000_1234_5678);

      // Reset while in REQ
      op(1'b0, 1'b1, 2'd2, 1'b0, 64'h8000_0004, 64'h5555_AAAA);
      tick(); idle_in(); reset = 1'b1;
      #1 chk("rreq_t1_dreq_valid", 64'(dreq_valid), 64'd1);
      chk("rreq_t1_strobe", 64'(dreq_strobe), 64'hF0);
      tick(); reset = 1'b0;
      #1 chk_reset_outs("rreq");
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
